// File: rtl/cache_invalidate_responder.sv
// cache_invalidate_responder
//   Cache-side receiver for coherence invalidates. Incoming addresses are
//   queued in a small circular FIFO. Each one is then looked up in the
//   direct-mapped tag/valid array, and the line's valid bit is cleared when
//   the stored tag matches.
//
// Ports
//   clock, reset          : single clock, asynchronous active-low reset
//   inv_valid/inv_ready   : invalidate request handshake, address on inv_addr
//   tag_rd_en/_index      : tag/valid array read strobe and line index
//   tag_rd_tag/_valid     : stored tag and valid bit, one cycle after tag_rd_en
//   fill_en/fill_index    : the cache is writing this line in the current cycle
//   valid_clr_en/_index   : clear the valid bit of this line on the next edge
//   inv_done/inv_hit      : one-cycle resolution pulse; inv_hit=1 means cleared
//   busy                  : FIFO non-empty or lookup in progress
//   dbg_state_o           : FSM state (0 IDLE, 1 ISSUE, 2 CHECK)
//
// Handshake: a request transfers on a rising clock edge where both inv_valid
// and inv_ready are 1. inv_ready does not depend on inv_valid. The sender
// must hold inv_valid and inv_addr stable until the transfer occurs.
module cache_invalidate_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INDEX_WIDTH = 6,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          inv_valid,
  input  logic [ADDR_WIDTH-1:0]         inv_addr,
  output logic                          inv_ready,
  output logic                          tag_rd_en,
  output logic [INDEX_WIDTH-1:0]        tag_rd_index,
  input  logic [ADDR_WIDTH-INDEX_WIDTH-1:0] tag_rd_tag,
  input  logic                          tag_rd_valid,
  input  logic                          fill_en,
  input  logic [INDEX_WIDTH-1:0]        fill_index,
  output logic                          valid_clr_en,
  output logic [INDEX_WIDTH-1:0]        valid_clr_index,
  output logic                          inv_done,
  output logic                          inv_hit,
  output logic                          busy,
  output logic [1:0]                    dbg_state_o
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;

  logic                   empty, full, push, pop;
  logic                   conflict, tag_match, decide;
  logic [INDEX_WIDTH-1:0] cur_index;
  logic [TAG_WIDTH-1:0]   cur_tag;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign cur_index = cur_addr_q[INDEX_WIDTH-1:0];
  assign cur_tag   = cur_addr_q[ADDR_WIDTH-1:INDEX_WIDTH];

  // A fill of the same line during CHECK means the read data may be stale.
  // In that case the line is reread and no decision is made.
  assign conflict  = fill_en && (fill_index == cur_index);
  assign tag_match = tag_rd_valid && (tag_rd_tag == cur_tag);
  assign decide    = (state_q == CHECK) && !conflict;

  // inv_ready is forced low while reset is held. It comes only from the
  // registered full flag, so a same-cycle pop never reopens a full buffer.
  assign inv_ready = !full && reset;
  assign push      = inv_valid && inv_ready;
  assign pop       = !empty && ((state_q == IDLE) || decide);

  assign busy        = !empty || (state_q != IDLE);
  assign dbg_state_o = state_q;

  assign wr_ptr_d   = wr_ptr_q + {{PTR_W{1'b0}}, push};
  assign rd_ptr_d   = rd_ptr_q + {{PTR_W{1'b0}}, pop};
  assign cur_addr_d = pop ? fifo_q[rd_ptr_q[PTR_W-1:0]] : cur_addr_q;

  // Entry storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= inv_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cur_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = ISSUE;
      ISSUE:   state_d = CHECK;
      CHECK: begin
        if (conflict || !empty) state_d = ISSUE;
        else                    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tag_rd_en       = 1'b0;
    tag_rd_index    = '0;
    valid_clr_en    = 1'b0;
    valid_clr_index = '0;
    inv_done        = 1'b0;
    inv_hit         = 1'b0;
    case (state_q)
      ISSUE: begin
        tag_rd_en    = 1'b1;
        tag_rd_index = cur_index;
      end
      CHECK: begin
        if (decide) begin
          inv_done = 1'b1;
          if (tag_match) begin
            inv_hit         = 1'b1;
            valid_clr_en    = 1'b1;
            valid_clr_index = cur_index;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_invalidate_responder.sv
// Directed bench for cache_invalidate_responder. A small behavioural
// tag/valid array answers reads one cycle after tag_rd_en and applies
// valid_clr_en on the clock edge. Inputs change and outputs are sampled
// on the falling edge.
module tb_cache_invalidate_responder;

  logic        clock;
  logic        reset;
  logic        inv_valid;
  logic [15:0] inv_addr;
  logic        inv_ready;
  logic        tag_rd_en;
  logic [5:0]  tag_rd_index;
  logic [9:0]  tag_rd_tag;
  logic        tag_rd_valid;
  logic        fill_en;
  logic [5:0]  fill_index;
  logic        valid_clr_en;
  logic [5:0]  valid_clr_index;
  logic        inv_done;
  logic        inv_hit;
  logic        busy;
  logic [1:0]  dbg_state_o;

  // Array model with its own write port, so that it is driven by one process only.
  logic [9:0]  tag_mem   [64];
  logic        valid_mem [64];
  logic        set_en;
  logic [5:0]  set_idx;
  logic [9:0]  set_tag;
  logic        set_valid;

  int n_checks;
  int n_fail;

  cache_invalidate_responder #(
    .ADDR_WIDTH (16),
    .INDEX_WIDTH(6),
    .FIFO_DEPTH (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .inv_valid      (inv_valid),
    .inv_addr       (inv_addr),
    .inv_ready      (inv_ready),
    .tag_rd_en      (tag_rd_en),
    .tag_rd_index   (tag_rd_index),
    .tag_rd_tag     (tag_rd_tag),
    .tag_rd_valid   (tag_rd_valid),
    .fill_en        (fill_en),
    .fill_index     (fill_index),
    .valid_clr_en   (valid_clr_en),
    .valid_clr_index(valid_clr_index),
    .inv_done       (inv_done),
    .inv_hit        (inv_hit),
    .busy           (busy),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (tag_rd_en) begin
      tag_rd_tag   <= tag_mem[tag_rd_index];
      tag_rd_valid <= valid_mem[tag_rd_index];
    end
    if (set_en) begin
      tag_mem[set_idx]   <= set_tag;
      valid_mem[set_idx] <= set_valid;
    end
    if (valid_clr_en) valid_mem[valid_clr_index] <= 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arr_set(input logic [5:0] idx, input logic [9:0] tag, input logic v);
    @(negedge clock);
    set_en = 1'b1; set_idx = idx; set_tag = tag; set_valid = v;
    @(negedge clock);
    set_en = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    inv_valid = 1'b0;
    inv_addr  = '0;
    fill_en   = 1'b0;
    fill_index = '0;
    set_en    = 1'b0;
    set_idx   = '0;
    set_tag   = '0;
    set_valid = 1'b0;

    // Reset state
    step(); step(); #1;
    chk("rst_ready", inv_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", tag_rd_en, 0);
    chk("rst_done", inv_done, 0);
    chk("rst_clr", valid_clr_en, 0);
    chk("rst_state", dbg_state_o, 0);
    step(); reset = 1'b1; #1;
    chk("rel_ready", inv_ready, 1);
    chk("rel_busy", busy, 0);

    // Single hit: line 5 holds tag 0x2A, addr 0x0A85
    arr_set(6'd5, 10'h2A, 1'b1);
    step(); inv_valid = 1'b1; inv_addr = 16'h0A85; #1;
    chk("t1_ready", inv_ready, 1);
    step(); inv_valid = 1'b0; #1;
    chk("t1_busy", busy, 1);
    chk("t1_no_rd_yet", tag_rd_en, 0);
    step(); #1;
    chk("t1_rd_en", tag_rd_en, 1);
    chk("t1_rd_idx", tag_rd_index, 5);
    step(); #1;
    chk("t1_done", inv_done, 1);
    chk("t1_hit", inv_hit, 1);
    chk("t1_clr", valid_clr_en, 1);
    chk("t1_clr_idx", valid_clr_index, 5);
    step(); #1;
    chk("t1_done_once", inv_done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_cleared", valid_mem[5], 0);

    // Miss: line 5 holds tag 0x2B; a fill of another line does not stall
    arr_set(6'd5, 10'h2B, 1'b1);
    step(); inv_valid = 1'b1; inv_addr = 16'h0A85;
    step(); inv_valid = 1'b0;
    step(); #1;
    chk("t2_rd_en", tag_rd_en, 1);
    step(); fill_en = 1'b1; fill_index = 6'd6; #1;
    chk("t2_done", inv_done, 1);
    chk("t2_hit", inv_hit, 0);
    chk("t2_clr", valid_clr_en, 0);
    step(); fill_en = 1'b0; #1;
    chk("t2_done_once", inv_done, 0);
    chk("t2_idle", busy, 0);
    chk("t2_kept", valid_mem[5], 1);

    // FIFO full while the head lookup is stalled by a fill of line 5
    arr_set(6'd5, 10'h2A, 1'b1);
    arr_set(6'd1, 10'h001, 1'b1);
    arr_set(6'd2, 10'h003, 1'b0);
    arr_set(6'd3, 10'h010, 1'b1);
    arr_set(6'd4, 10'h3FF, 1'b1);
    step(); fill_en = 1'b1; fill_index = 6'd5; inv_valid = 1'b1; inv_addr = 16'h0A85;
    step(); inv_valid = 1'b0;
    step(); #1;
    chk("t3_rd_x", tag_rd_en, 1);
    step(); inv_valid = 1'b1; inv_addr = 16'h0041; #1;
    chk("t3_stall_done", inv_done, 0);
    chk("t3_ready_a", inv_ready, 1);
    step(); inv_addr = 16'h00C2; #1;
    chk("t3_ready_b", inv_ready, 1);
    step(); inv_addr = 16'h0403; #1;
    chk("t3_ready_c", inv_ready, 1);
    step(); inv_addr = 16'hFFC4; #1;
    chk("t3_ready_d", inv_ready, 1);
    step(); inv_addr = 16'h0186; #1;
    chk("t3_full", inv_ready, 0);
    chk("t3_stall_done2", inv_done, 0);
    step(); #1;
    chk("t3_full2", inv_ready, 0);
    step(); inv_valid = 1'b0; fill_en = 1'b0; #1;
    chk("t3_x_done", inv_done, 1);
    chk("t3_x_hit", inv_hit, 1);
    chk("t3_x_idx", valid_clr_index, 5);
    chk("t3_full_on_pop", inv_ready, 0);
    step(); #1;
    chk("t3_ready_back", inv_ready, 1);
    chk("t3_a_rd_idx", tag_rd_index, 1);
    chk("t3_a_gap", inv_done, 0);
    step(); #1;
    chk("t3_a_done", inv_done, 1);
    chk("t3_a_hit", inv_hit, 1);
    chk("t3_a_idx", valid_clr_index, 1);
    step(); #1;
    chk("t3_b_rd_idx", tag_rd_index, 2);
    step(); #1;
    chk("t3_b_done", inv_done, 1);
    chk("t3_b_miss", inv_hit, 0);
    chk("t3_b_noclr", valid_clr_en, 0);
    step(); #1;
    chk("t3_c_rd_idx", tag_rd_index, 3);
    step(); #1;
    chk("t3_c_done", inv_done, 1);
    chk("t3_c_idx", valid_clr_index, 3);
    step(); #1;
    chk("t3_d_rd_idx", tag_rd_index, 4);
    step(); #1;
    chk("t3_d_done", inv_done, 1);
    chk("t3_d_hit", inv_hit, 1);
    chk("t3_d_idx", valid_clr_index, 4);
    step(); #1;
    chk("t3_end_done", inv_done, 0);
    chk("t3_end_busy", busy, 0);

    // Fill conflict on two consecutive CHECK cycles; the first read sees stale valid=0
    arr_set(6'd7, 10'h015, 1'b0);
    step(); inv_valid = 1'b1; inv_addr = 16'h0547;
    step(); inv_valid = 1'b0;
    step(); #1;
    chk("t4_rd_idx", tag_rd_index, 7);
    step(); fill_en = 1'b1; fill_index = 6'd7;
    set_en = 1'b1; set_idx = 6'd7; set_tag = 10'h015; set_valid = 1'b1; #1;
    chk("t4_c1_done", inv_done, 0);
    chk("t4_c1_clr", valid_clr_en, 0);
    step(); fill_en = 1'b0; set_en = 1'b0; #1;
    chk("t4_reread1", tag_rd_en, 1);
    step(); fill_en = 1'b1; #1;
    chk("t4_c2_done", inv_done, 0);
    step(); fill_en = 1'b0; #1;
    chk("t4_reread2", tag_rd_en, 1);
    step(); #1;
    chk("t4_done", inv_done, 1);
    chk("t4_hit", inv_hit, 1);
    chk("t4_idx", valid_clr_index, 7);
    step(); #1;
    chk("t4_done_once", inv_done, 0);
    chk("t4_idle", busy, 0);
    chk("t4_cleared", valid_mem[7], 0);

    // Reset during CHECK with three requests queued
    arr_set(6'd8, 10'h001, 1'b1);
    arr_set(6'd9, 10'h001, 1'b1);
    arr_set(6'd10, 10'h001, 1'b1);
    step(); inv_valid = 1'b1; inv_addr = 16'h0048;
    step(); inv_addr = 16'h0049;
    step(); inv_addr = 16'h004A;
    step(); inv_valid = 1'b0; #1;
    chk("t5_in_check", dbg_state_o, 2);
    reset = 1'b0; #1;
    chk("t5_done", inv_done, 0);
    chk("t5_clr", valid_clr_en, 0);
    chk("t5_ready", inv_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_state", dbg_state_o, 0);
    step(); #1;
    chk("t5_done_hold", inv_done, 0);
    step(); reset = 1'b1; #1;
    chk("t5_rel_ready", inv_ready, 1);
    chk("t5_rel_busy", busy, 0);
    step(); #1;
    chk("t5_no_rd", tag_rd_en, 0);
    chk("t5_still_idle", busy, 0);
    chk("t5_kept8", valid_mem[8], 1);
    chk("t5_kept10", valid_mem[10], 1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_invalidate_responder.md
# cache_invalidate_responder

Cache-side receiver for the coherence invalidate channel. Accepts invalidate addresses sent by `cache_coherenter` for this cache, buffers them, looks each one up in the cache's tag/valid array, and clears the line's valid bit when the tag matches. One instance sits in front of each of the two caches, between the coherenter's `cache_invalidate_N` output and the cache's tag/valid storage.

## Interface
- `ADDR_WIDTH`, 16, invalidate address width; matches the `INVALIDATE_ADDRESS` field.
- `INDEX_WIDTH`, 6, line index bits (direct-mapped, 64 lines); index = `addr[INDEX_WIDTH-1:0]`, tag = `addr[ADDR_WIDTH-1:INDEX_WIDTH]`.
- `FIFO_DEPTH`, 4, pending-invalidate buffer entries; a power of two, at least 2.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inv_valid`  in  1  invalidate request present.
- `inv_addr`  in  ADDR_WIDTH  address to invalidate.
- `inv_ready`  out  1  buffer can accept; a transfer occurs on a rising edge with `inv_valid && inv_ready`.
- `tag_rd_en`  out  1  tag/valid array read strobe.
- `tag_rd_index`  out  INDEX_WIDTH  line to read.
- `tag_rd_tag`  in  ADDR_WIDTH-INDEX_WIDTH  stored tag, valid the cycle after `tag_rd_en`.
- `tag_rd_valid`  in  1  stored valid bit, same timing as `tag_rd_tag`.
- `fill_en`  in  1  the cache is writing or refilling a line this cycle.
- `fill_index`  in  INDEX_WIDTH  line being written.
- `valid_clr_en`  out  1  clear the valid bit at `valid_clr_index` on this edge.
- `valid_clr_index`  out  INDEX_WIDTH  line to clear.
- `inv_done`  out  1  one-cycle pulse: the current request is resolved.
- `inv_hit`  out  1  qualifies `inv_done`: 1 means a line was cleared.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.

## Operation
- FIFO:
  - Circular buffer with pointers one bit wider than log2(FIFO_DEPTH); pointers wrap.
  - `inv_ready = !full && reset` (deasserted while reset is held).
  - Push and pop in the same cycle are allowed when not full.
  - When full, `inv_ready` stays 0 even if a pop happens in the same cycle.
- FSM states: IDLE, ISSUE, CHECK.
  - IDLE: if the FIFO is non-empty, pop the head into `cur_addr` and go to ISSUE; otherwise stay.
  - ISSUE: `tag_rd_en=1`, `tag_rd_index=cur_addr[INDEX]`; go to CHECK.
  - CHECK, conflict (`fill_en && fill_index==cur_index`): the read data is stale. No decision; go to ISSUE and reread. Repeat for as long as the conflict persists.
  - CHECK, hit (`tag_rd_valid && tag_rd_tag==cur_tag`): `valid_clr_en=1`, `valid_clr_index=cur_index`, `inv_done=1`, `inv_hit=1`.
  - CHECK, miss: `inv_done=1`, `inv_hit=0`, no clear.
  - CHECK, after a hit or miss: if the FIFO is non-empty, pop the next entry and go to ISSUE; otherwise go to IDLE.
- Duplicate addresses in the FIFO are each processed. The second lookup of the same address misses because the line was already cleared.
- CHECK outputs are combinational from the state and the tag read data. All other outputs are decoded from registered state.

## Timing
- Reset values: state IDLE, FIFO empty, `cur_addr=0`, all outputs 0 (including `inv_ready` while reset is low). `inv_ready` rises in the first cycle after reset deasserts.
- Reset asserted mid-operation: queued and in-flight requests are discarded, with no `inv_done` and no clear.
- Latency: request accepted at edge E0 into an empty, idle block → pop at E1 → ISSUE cycle (E1–E2) → CHECK cycle (E2–E3), where `inv_done` and `valid_clr_en` are high. The clear takes effect at E3.
- Throughput: one request per 2 cycles when the FIFO stays non-empty (CHECK→ISSUE).
- Each conflict retry adds 2 cycles.
- `inv_done` is high for exactly one cycle per accepted request, in FIFO order.

## Test plan
- Reset then single hit: the array holds index 0x05 with tag 0x2A and valid=1. Send `inv_addr=0x0A85` → `tag_rd_en` two cycles after acceptance, then `valid_clr_en=1` with index 0x05, `inv_done=1`, `inv_hit=1`.
- Miss: the same line holds tag 0x2B. Send 0x0A85 → `inv_done=1`, `inv_hit=0`, `valid_clr_en` stays 0.
- FIFO full: stall the array by holding `fill_en` on a matching index and push 5 requests back-to-back → `inv_ready` drops after the 4th acceptance. Release the fill → all 4 complete in order, at 2 cycles each.
- Fill conflict: during CHECK drive `fill_en=1` with `fill_index` = the current index for 2 consecutive CHECK cycles → two rereads, then a normal decision. `inv_done` pulses only once.
- Reset mid-operation: 3 requests queued, pull `reset` low during CHECK → all outputs 0 immediately, no `inv_done`. After release, `busy=0` and `inv_ready=1`.
